adder_tree_pipe: RTL

- Parametrised, pipelined successor to the single-cycle adder/register block.
- Sums N_OPS unsigned operands plus a carry-in through a registered binary adder tree.
- Optionally accumulates each result into the previous one, with saturate or wrap mode.
- Registered zero and overflow flags; valid/ready handshake on both sides.
- Sits between operand packers and downstream consumers in datapath clusters.

---
 rtl/adder_pkg.sv | 26 ++
 rtl/adder_tree_level.sv | 57 +++++
 rtl/adder_tree_pipe.sv | 119 +++++++++++
 3 files changed

// File: rtl/adder_pkg.sv
// Shared helpers for the pipelined adder tree: width arithmetic and the
// saturation-mode enum used to bind the SAT parameter readably.
package adder_pkg;

    typedef enum logic {
        WRAP     = 1'b0,
        SATURATE = 1'b1
    } sat_mode_t;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int v = 1; v < n; v = v << 1) begin
            r = r + 1;
        end
        return r;
    endfunction

    // Smallest accumulator that holds a full tree sum plus one accumulate step.
    function automatic int min_w_acc(input int n_ops, input int w_in);
        return w_in + clog2(n_ops) + 1;
    endfunction

    localparam int DEFAULT_MIN_W_ACC = min_w_acc(4, 16);

endpackage

// File: rtl/adder_tree_level.sv
// One registered level of the adder tree: adds adjacent operand pairs into
// results one bit wider, optionally folding a carry-in into the first pair.
module adder_tree_level #(
    parameter int N_IN    = 4,
    parameter int W       = 16,
    parameter bit USE_CIN = 1'b0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_en,
    input  logic                       i_valid,
    input  logic [N_IN*W-1:0]          i_data,
    input  logic                       i_cin,
    input  logic                       i_acc,
    output logic                       o_valid,
    output logic [(N_IN/2)*(W+1)-1:0]  o_data,
    output logic                       o_acc
);

    localparam int N_OUT = N_IN / 2;

    logic [N_OUT*(W+1)-1:0] w_sum;
    logic [W:0]             w_cin;

    logic                   r_valid;
    logic [N_OUT*(W+1)-1:0] r_data;
    logic                   r_acc;

    assign w_cin = {{W{1'b0}}, (USE_CIN ? i_cin : 1'b0)};

    // The carry fits in the widened first pair: 2*(2^W-1)+1 < 2^(W+1).
    always_comb begin
        w_sum = '0;
        for (int k = 0; k < N_OUT; k++) begin
            w_sum[k*(W+1) +: (W+1)] = {1'b0, i_data[(2*k)*W +: W]}
                                    + {1'b0, i_data[(2*k+1)*W +: W]}
                                    + ((k == 0) ? w_cin : '0);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_acc   <= 1'b0;
        end else if (i_en) begin
            r_valid <= i_valid;
            r_data  <= w_sum;
            r_acc   <= i_acc;
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;
    assign o_acc   = r_acc;

endmodule

// File: rtl/adder_tree_pipe.sv
// Pipelined N-operand adder with carry-in, optional accumulate onto the last
// emitted result, wrap or saturate on overflow, and valid/ready on both sides.
module adder_tree_pipe
    import adder_pkg::*;
#(
    parameter int N_OPS = 4,
    parameter int W_IN  = 16,
    parameter int W_ACC = 24,
    parameter int SAT   = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [N_OPS*W_IN-1:0]   in_data,
    input  logic                    in_cin,
    input  logic                    in_acc,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [W_ACC-1:0]        out_sum,
    output logic                    out_zero,
    output logic                    out_ovf
);

    localparam int        LV   = clog2(N_OPS);
    localparam int        WT   = W_IN + LV;
    localparam sat_mode_t MODE = (SAT != 0) ? SATURATE : WRAP;

    logic             w_stall;
    logic [WT-1:0]    w_tree_sum;
    logic             w_tree_valid;
    logic             w_tree_acc;
    logic [W_ACC:0]   w_full;
    logic [W_ACC-1:0] w_next;

    logic             r_out_valid;
    logic [W_ACC-1:0] r_sum;
    logic             r_zero;
    logic             r_ovf;

    // One global stall freezes every stage, so set order and in_acc pairing hold.
    assign w_stall  = r_out_valid & ~out_ready;
    assign in_ready = ~w_stall;

    for (genvar i = 1; i <= LV; i++) begin : g_lvl
        localparam int NI = N_OPS >> (i - 1);
        localparam int WI = W_IN + i - 1;

        logic [NI*WI-1:0]          w_in_data;
        logic                      w_in_valid;
        logic                      w_in_acc;
        logic [(NI/2)*(WI+1)-1:0]  w_data;
        logic                      w_valid;
        logic                      w_acc;

        if (i == 1) begin : g_src
            assign w_in_data  = in_data;
            assign w_in_valid = in_valid;
            assign w_in_acc   = in_acc;
        end else begin : g_src
            assign w_in_data  = g_lvl[i-1].w_data;
            assign w_in_valid = g_lvl[i-1].w_valid;
            assign w_in_acc   = g_lvl[i-1].w_acc;
        end

        adder_tree_level #(
            .N_IN    (NI),
            .W       (WI),
            .USE_CIN (i == 1)
        ) u_level (
            .clk     (clk),
            .rst     (rst),
            .i_en    (~w_stall),
            .i_valid (w_in_valid),
            .i_data  (w_in_data),
            .i_cin   (in_cin),
            .i_acc   (w_in_acc),
            .o_valid (w_valid),
            .o_data  (w_data),
            .o_acc   (w_acc)
        );
    end

    assign w_tree_sum   = g_lvl[LV].w_data;
    assign w_tree_valid = g_lvl[LV].w_valid;
    assign w_tree_acc   = g_lvl[LV].w_acc;

    // r_sum doubles as the accumulator: it always equals the last emitted result.
    always_comb begin
        w_full = (w_tree_acc ? {1'b0, r_sum} : '0)
               + {{(W_ACC + 1 - WT){1'b0}}, w_tree_sum};
        w_next = w_full[W_ACC-1:0];
        if (MODE == SATURATE && w_full[W_ACC]) begin
            w_next = '1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_sum       <= '0;
            r_zero      <= 1'b0;
            r_ovf       <= 1'b0;
        end else if (!w_stall) begin
            r_out_valid <= w_tree_valid;
            if (w_tree_valid) begin
                r_sum  <= w_next;
                r_zero <= (w_next == '0);
                r_ovf  <= w_full[W_ACC];
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_sum   = r_sum;
    assign out_zero  = r_zero;
    assign out_ovf   = r_ovf;

endmodule
